// File: rtl/im_sequencer_if.sv
// Bundles the sequencer's three bus groups: the external word stream, the
// instruction memory write port, and the datapath PC/instruction handshake.
interface im_sequencer_if #(
  parameter int unsigned DATA_W = 32
);

  // External configuration stream
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  // Instruction memory external write port
  logic              wr_en_ext_im;
  logic [DATA_W-1:0] wr_addr_ext_im;
  logic [DATA_W-1:0] wr_data_ext_im;

  // Datapath stepping handshake
  logic [31:0]       PC;
  logic              instr_valid;
  logic              instr_done;

  // Sequencer side
  modport master (
    input  s_valid,
    input  s_data,
    input  instr_done,
    output s_ready,
    output wr_en_ext_im,
    output wr_addr_ext_im,
    output wr_data_ext_im,
    output PC,
    output instr_valid
  );

  // Environment side (config source, memory, datapath)
  modport slave (
    output s_valid,
    output s_data,
    output instr_done,
    input  s_ready,
    input  wr_en_ext_im,
    input  wr_addr_ext_im,
    input  wr_data_ext_im,
    input  PC,
    input  instr_valid
  );

endinterface

// File: rtl/im_sequencer.sv
// Instruction memory sequencer: loads external words into the (entry, field)
// address space of the instruction memory, then steps PC through the stored
// instructions, one datapath handshake per instruction.
module im_sequencer #(
  parameter int unsigned IM_SIZE   = 2,
  parameter int unsigned IM_FIELDS = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [6:0]  load_count,
  input  logic        run_start,
  input  logic [15:0] num_instr,
  input  logic        abort,
  output logic        load_done,
  output logic        run_done,
  output logic        busy,
  im_sequencer_if.master bus
);

  localparam int unsigned TOTAL   = IM_SIZE * IM_FIELDS;
  localparam int unsigned TOT_W   = $clog2(TOTAL + 1);
  localparam int unsigned REM_W   = (TOT_W > 7) ? TOT_W : 7;
  localparam int unsigned WIDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned LEFT_W  = 16;
  localparam int unsigned PC_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e              state_q,       state_d;
  logic [REM_W-1:0]    remaining_q,   remaining_d;
  logic [WIDX_W-1:0]   widx_q,        widx_d;
  logic [LEFT_W-1:0]   left_q,        left_d;
  logic [PC_W-1:0]     pc_q,          pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                wr_en_q,       wr_en_d;
  logic [DATA_W-1:0]   wr_addr_q,     wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q,     wr_data_d;
  logic                load_done_q,   load_done_d;
  logic                run_done_q,    run_done_d;

  logic                s_ready;
  logic                handshake;
  logic                step;
  logic [REM_W-1:0]    load_clamped;

  // Stream readiness depends on the registered state only, never on s_valid.
  assign s_ready      = (state_q == ST_LOAD);
  assign handshake    = bus.s_valid & s_ready;
  assign step         = bus.instr_done & instr_valid_q;
  assign load_clamped = (REM_W'(load_count) > REM_W'(TOTAL)) ? REM_W'(TOTAL)
                                                              : REM_W'(load_count);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      widx_q        <= '0;
      left_q        <= '0;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      load_done_q   <= 1'b0;
      run_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      widx_q        <= widx_d;
      left_q        <= left_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      load_done_q   <= load_done_d;
      run_done_q    <= run_done_d;
    end
  end

  // Next-state and registered-output logic; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    widx_d        = widx_q;
    left_d        = left_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    load_done_d   = 1'b0;
    run_done_d    = 1'b0;

    if (abort) begin
      state_d       = ST_IDLE;
      remaining_d   = '0;
      widx_d        = '0;
      left_d        = '0;
      pc_d          = '0;
      instr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Load takes precedence when both starts arrive together.
          if (load_start) begin
            if (load_count == 7'd0) begin
              load_done_d = 1'b1;
            end else begin
              state_d     = ST_LOAD;
              remaining_d = load_clamped;
              widx_d      = '0;
            end
          end else if (run_start) begin
            if (num_instr == 16'd0) begin
              run_done_d = 1'b1;
            end else begin
              state_d       = ST_RUN;
              pc_d          = '0;
              left_d        = num_instr;
              instr_valid_d = 1'b1;
            end
          end
        end

        ST_LOAD: begin
          // With 32 fields per entry, {entry, field} is just the word index.
          if (handshake) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = DATA_W'(widx_q);
            wr_data_d   = bus.s_data;
            widx_d      = widx_q + WIDX_W'(1);
            remaining_d = remaining_q - REM_W'(1);
            if (remaining_q == REM_W'(1)) begin
              state_d     = ST_IDLE;
              load_done_d = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (step) begin
            left_d = left_q - LEFT_W'(1);
            if (left_q == LEFT_W'(1)) begin
              state_d       = ST_IDLE;
              instr_valid_d = 1'b0;
              pc_d          = '0;
              run_done_d    = 1'b1;
            end else if (pc_q == PC_W'(IM_SIZE - 1)) begin
              pc_d = '0;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready        = s_ready;
  assign bus.wr_en_ext_im   = wr_en_q;
  assign bus.wr_addr_ext_im = wr_addr_q;
  assign bus.wr_data_ext_im = wr_data_q;
  assign bus.PC             = pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign load_done          = load_done_q;
  assign run_done           = run_done_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_im_sequencer.sv
// Directed bench for im_sequencer: reset, full and clamped loads, PC wrap,
// start collisions, zero counts, abort and asynchronous reset.
module tb_im_sequencer;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [6:0]  load_count;
  logic        run_start;
  logic [15:0] num_instr;
  logic        abort;
  logic        load_done;
  logic        run_done;
  logic        busy;

  int checks;
  int errors;

  im_sequencer_if #(.DATA_W(32)) bus ();

  im_sequencer #(
    .IM_SIZE  (2),
    .IM_FIELDS(32),
    .DATA_W   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .load_count(load_count),
    .run_start (run_start),
    .num_instr (num_instr),
    .abort     (abort),
    .load_done (load_done),
    .run_done  (run_done),
    .busy      (busy),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_start      = 1'($urandom_range(0, 1));
      load_count      = 7'($urandom);
      run_start       = 1'($urandom_range(0, 1));
      num_instr       = 16'($urandom);
      abort           = 1'($urandom_range(0, 1));
      bus.s_valid     = 1'($urandom_range(0, 1));
      bus.s_data      = $urandom;
      bus.instr_done  = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (bus.s_ready !== 1'b0 || bus.wr_en_ext_im !== 1'b0 || bus.wr_addr_ext_im !== 32'h0 ||
        bus.wr_data_ext_im !== 32'h0 || bus.PC !== 32'h0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus rdy=%0b wen=%0b addr=%h data=%h pc=%h iv=%0b want all 0",
               bus.s_ready, bus.wr_en_ext_im, bus.wr_addr_ext_im, bus.wr_data_ext_im,
               bus.PC, bus.instr_valid);
    end
    checks++;
    if (load_done !== 1'b0 || run_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ld=%0b rd=%0b busy=%0b want 0 0 0", load_done, run_done, busy);
    end
    load_start = 0; load_count = 0; run_start = 0; num_instr = 0; abort = 0;
    bus.s_valid = 0; bus.s_data = 0; bus.instr_done = 0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    logic [31:0] addr33;
    logic [31:0] data33;
    addr33 = 32'hx; data33 = 32'hx;
    load_start = 1; load_count = 7'd64;
    tick();
    load_start = 0;
    checks++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_load_enter rdy=%0b busy=%0b want 1 1", bus.s_ready, busy);
    end
    for (int i = 0; i < 64; i++) begin
      bus.s_valid = 1;
      bus.s_data  = 32'h1000 + 32'(i);
      tick();
      checks++;
      if (bus.wr_en_ext_im !== 1'b1 || bus.wr_addr_ext_im !== 32'(i) ||
          bus.wr_data_ext_im !== 32'h1000 + 32'(i) || load_done !== 1'(i == 63)) begin
        errors++;
        $display("FAIL full_load_word %0d wen=%0b addr=%h data=%h ld=%0b want 1 %h %h %0b",
                 i, bus.wr_en_ext_im, bus.wr_addr_ext_im, bus.wr_data_ext_im, load_done,
                 32'(i), 32'h1000 + 32'(i), i == 63);
      end
      if (i == 33) begin
        addr33 = bus.wr_addr_ext_im;
        data33 = bus.wr_data_ext_im;
      end
    end
    checks++;
    if (addr33 !== 32'h21 || data33 !== 32'h1021) begin
      errors++;
      $display("FAIL full_load_word33 addr=%h data=%h want 00000021 00001021", addr33, data33);
    end
    checks++;
    if (bus.s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_load_exit rdy=%0b busy=%0b want 0 0", bus.s_ready, busy);
    end
    bus.s_valid = 0;
    tick();
    checks++;
    if (bus.wr_en_ext_im !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL full_load_after wen=%0b ld=%0b want 0 0", bus.wr_en_ext_im, load_done);
    end
  endtask

  task automatic test_gapped_load();
    int exp_written;
    int writes;
    int dones;
    int bad;
    logic exp_rdy;
    logic hs;
    exp_written = 0; writes = 0; dones = 0; bad = 0;
    load_start = 1; load_count = 7'd100;
    tick();
    load_start = 0;
    for (int c = 0; c < 140; c++) begin
      exp_rdy     = (exp_written < 64);
      bus.s_valid = (c % 2 == 0);
      bus.s_data  = 32'h2000 + 32'(exp_written);
      if (bus.s_ready !== exp_rdy) bad++;
      hs = bus.s_valid && exp_rdy;
      tick();
      if (bus.wr_en_ext_im) writes++;
      if (load_done) dones++;
      if (bus.wr_en_ext_im !== hs) bad++;
      if (hs) begin
        if (bus.wr_data_ext_im !== 32'h2000 + 32'(exp_written) ||
            bus.wr_addr_ext_im !== 32'(exp_written)) bad++;
        exp_written++;
        if (load_done !== 1'(exp_written == 64)) bad++;
      end
    end
    bus.s_valid = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gapped_load_cycles bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (writes != 64 || dones != 1) begin
      errors++;
      $display("FAIL gapped_load_totals writes=%0d dones=%0d want 64 1", writes, dones);
    end
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL gapped_load_exit rdy=%0b want 0", bus.s_ready);
    end
  endtask

  task automatic test_run_wrap();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    run_start = 1; num_instr = 16'd5;
    tick();
    run_start = 0;
    bus.instr_done = 1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus.PC !== exp_pc[j] || bus.instr_valid !== 1'b1 || run_done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_wrap_step %0d pc=%0d iv=%0b rd=%0b busy=%0b want %0d 1 0 1",
                 j, bus.PC, bus.instr_valid, run_done, busy, exp_pc[j]);
      end
      tick();
    end
    checks++;
    if (run_done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.PC !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_wrap_done rd=%0b iv=%0b pc=%0d busy=%0b want 1 0 0 0",
               run_done, bus.instr_valid, bus.PC, busy);
    end
    tick();
    checks++;
    if (run_done !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_wrap_after rd=%0b iv=%0b want 0 0", run_done, bus.instr_valid);
    end
    bus.instr_done = 0;
  endtask

  task automatic test_collisions();
    load_start = 1; load_count = 7'd2; run_start = 1; num_instr = 16'd3;
    tick();
    load_start = 0; run_start = 0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_both rdy=%0b iv=%0b want 1 0", bus.s_ready, bus.instr_valid);
    end
    run_start = 1; num_instr = 16'd3;
    tick();
    run_start = 0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_run_in_load rdy=%0b iv=%0b want 1 0", bus.s_ready, bus.instr_valid);
    end
    bus.s_valid = 1; bus.s_data = 32'hAAAA_0000;
    tick();
    bus.s_data = 32'hAAAA_0001;
    tick();
    bus.s_valid = 0;
    checks++;
    if (bus.wr_en_ext_im !== 1'b1 || bus.wr_addr_ext_im !== 32'h1 ||
        bus.wr_data_ext_im !== 32'hAAAA_0001 || load_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL collide_load_end wen=%0b addr=%h data=%h ld=%0b busy=%0b want 1 1 aaaa0001 1 0",
               bus.wr_en_ext_im, bus.wr_addr_ext_im, bus.wr_data_ext_im, load_done, busy);
    end
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL collide_no_run iv=%0b busy=%0b want 0 0", bus.instr_valid, busy);
    end
    run_start = 1; num_instr = 16'd0;
    tick();
    run_start = 0;
    checks++;
    if (run_done !== 1'b1 || busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_run rd=%0b busy=%0b iv=%0b want 1 0 0", run_done, busy, bus.instr_valid);
    end
    tick();
    checks++;
    if (run_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_run_pulse rd=%0b want 0", run_done);
    end
    load_start = 1; load_count = 7'd0;
    tick();
    load_start = 0;
    checks++;
    if (load_done !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_load ld=%0b busy=%0b rdy=%0b want 1 0 0", load_done, busy, bus.s_ready);
    end
    tick();
  endtask

  task automatic test_abort();
    int wcount;
    int extra;
    int ldone;
    wcount = 0; extra = 0; ldone = 0;
    load_start = 1; load_count = 7'd20;
    tick();
    load_start = 0;
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1;
      bus.s_data  = 32'h3000 + 32'(i);
      tick();
      if (bus.wr_en_ext_im) wcount++;
      if (load_done) ldone++;
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (bus.wr_en_ext_im !== 1'b0 || bus.s_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_load_state wen=%0b rdy=%0b busy=%0b ld=%0b want 0 0 0 0",
               bus.wr_en_ext_im, bus.s_ready, busy, load_done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.wr_en_ext_im) extra++;
      if (load_done) ldone++;
    end
    bus.s_valid = 0;
    checks++;
    if (wcount != 10 || extra != 0 || ldone != 0) begin
      errors++;
      $display("FAIL abort_load_count writes=%0d extra=%0d ld=%0d want 10 0 0", wcount, extra, ldone);
    end
    run_start = 1; num_instr = 16'd4;
    tick();
    run_start = 0;
    bus.instr_done = 1;
    tick();
    bus.instr_done = 0;
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (bus.PC !== 32'd0 || bus.instr_valid !== 1'b0 || run_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_run pc=%0d iv=%0b rd=%0b busy=%0b want 0 0 0 0",
               bus.PC, bus.instr_valid, run_done, busy);
    end
    tick();
    checks++;
    if (run_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_run_pulse rd=%0b want 0", run_done);
    end
  endtask

  task automatic test_async_reset();
    run_start = 1; num_instr = 16'd10;
    tick();
    run_start = 0;
    bus.instr_done = 1;
    tick();
    bus.instr_done = 0;
    checks++;
    if (bus.PC !== 32'd1 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_pre pc=%0d iv=%0b want 1 1", bus.PC, bus.instr_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.PC !== 32'd0 || bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pc=%0d iv=%0b busy=%0b want 0 0 0", bus.PC, bus.instr_valid, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.PC !== 32'd0 || bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after pc=%0d iv=%0b busy=%0b want 0 0 0", bus.PC, bus.instr_valid, busy);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    load_start = 0; load_count = 0; run_start = 0; num_instr = 0; abort = 0;
    bus.s_valid = 0; bus.s_data = 0; bus.instr_done = 0;
    test_reset();
    test_full_load();
    test_gapped_load();
    test_run_wrap();
    test_collisions();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_sequencer.md
# im_sequencer

Controller that owns the instruction memory's external write port and its `PC` input. It loads a stream of 32-bit instruction words from the external port into the memory's (entry, field) address space. It then steps `PC` through the stored instructions, handshaking each one with the compute datapath. It sits between the external configuration interface and `instruction_memory`, and is the only driver of `wr_*_ext_im` and `PC`.

## Interface
Parameters:
- `IM_SIZE`, 2, number of instruction entries (power of two).
- `IM_FIELDS`, 32, 32-bit fields per entry (fixed at 32: field index is address bits [4:0]).
- `DATA_W`, 32, external data/address width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse; begin a load of `load_count` words.
- `load_count`  in  7  words to load, sampled with `load_start`.
- `s_valid`  in  1  external word valid.
- `s_data`  in  DATA_W  external instruction word.
- `s_ready`  out  1  block accepts a word this cycle.
- `wr_en_ext_im`  out  1  memory write strobe.
- `wr_addr_ext_im`  out  DATA_W  {entry, field[4:0]}.
- `wr_data_ext_im`  out  DATA_W  word to write.
- `run_start`  in  1  pulse; begin executing `num_instr` instructions.
- `num_instr`  in  16  instruction count, sampled with `run_start`.
- `instr_done`  in  1  datapath finished current instruction.
- `abort`  in  1  return to IDLE from any state.
- `PC`  out  32  instruction entry index.
- `instr_valid`  out  1  `PC` and memory output are valid for the datapath.
- `load_done`  out  1  one-cycle pulse.
- `run_done`  out  1  one-cycle pulse.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - `load_start` -> LOAD, with `remaining = min(load_count, IM_SIZE*IM_FIELDS)` and word index `widx = 0`.
  - `run_start` -> RUN, with `PC = 0` and `left = num_instr`.
  - If both starts are asserted in the same cycle, load wins and `run_start` is dropped.
  - Starts arriving outside IDLE are ignored.
- Zero count: `load_count == 0` or `num_instr == 0` does not leave IDLE. The matching done pulse is issued the next cycle.
- LOAD:
  - `s_ready = 1`. A handshake is `s_valid & s_ready`.
  - Each handshake registers `wr_en_ext_im = 1`, `wr_addr_ext_im = {widx/32, widx%32}` (upper bits zero-extended), `wr_data_ext_im = s_data`, then `widx++` and `remaining--`.
  - On the handshake that takes `remaining` to 0, go to IDLE. `load_done` pulses in the same cycle as that final `wr_en_ext_im`.
- RUN:
  - `instr_valid = 1`.
  - `instr_done` while `instr_valid`: `left--`. If `left` becomes 0, go to IDLE, drop `instr_valid`, set `PC = 0` and pulse `run_done` next cycle. Otherwise `PC = (PC == IM_SIZE-1) ? 0 : PC+1`, and `instr_valid` stays high.
  - `instr_done` while not `instr_valid` is ignored.
- `abort`: highest priority. Next state is IDLE. `PC`, counters and all strobes are cleared, and no done pulse is issued. A write already registered in the cycle `abort` is sampled still completes.
- Reset values: `s_ready=0`, `wr_en_ext_im=0`, `wr_addr_ext_im=0`, `wr_data_ext_im=0`, `PC=0`, `instr_valid=0`, `load_done=0`, `run_done=0`, `busy=0`, state IDLE.
- Reset mid-operation discards any partial load or run. Memory contents already written are not altered by this block.

## Timing
- Start to active: the start is sampled at edge k. `s_ready` or `instr_valid` is high from cycle k+1.
- Write latency: a handshake at edge k gives `wr_en_ext_im` high during cycle k+1 (registered, one cycle per word). Back-to-back handshakes sustain 1 word/cycle.
- `s_ready` is combinational from state only, not from `s_valid`.
- `PC` changes only on the edge where `instr_done & instr_valid` is sampled. The datapath sees the new instruction in the following cycle, since memory read is combinational on `PC`.
- `busy` follows the registered state. It is high from the cycle after the start through the cycle of the final write / last `instr_done` edge. It is low during the done-pulse cycle.

## Test plan
- Reset: hold `reset` low for 3 cycles with random inputs. All outputs are 0, `busy = 0`.
- Full load: `load_count = 64`, 64 consecutive valid words `0x1000+i`. Expect 64 writes with addr i=33 -> `0x21`, data `0x1021`. `load_done` coincides with the 64th write, after which `s_ready = 0`.
- Gapped and clamped load: `load_count = 100` with `s_valid` toggling every other cycle. Exactly 64 writes occur, one per handshake, with no write in gap cycles.
- Run with wrap: `num_instr = 5`, `instr_done` held high. `PC` sequence is 0,1,0,1,0, then `run_done` one cycle after the 5th done, and `PC` returns to 0.
- Collisions: `load_start` and `run_start` in the same cycle enter LOAD only. `run_start` during LOAD is ignored. `num_instr = 0` gives `run_done` next cycle with `busy` staying 0.
- Abort/reset mid-op: `abort` after 10 of 20 words stops writes at 10, `s_ready = 0`, and no `load_done`. Async `reset` during RUN with `PC = 1` forces `PC = 0` and `instr_valid = 0` immediately, without waiting for a clock edge.
